lcd_bus_master: RTL and testbench

- Host-side initiator for the 24-bit 8080-style parallel LCD bus (blk, cs, rs, wr, rd, rst, data).
- It turns a valid/ready command stream into correctly timed write and read strobes.
- It generates the panel hardware-reset sequence, returns read data on a response strobe, and registers the backlight enable.
- It sits between the display logic and the LCD pass-through converter, and drives that converter's sblk/scs/srs/swr/srd/srst/sdata inputs.

---
 rtl/lcd_bus_master.sv | 180 ++++++++++++++++++
 tb/tb_lcd_bus_master.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_master.sv
// Host-side initiator for a 24-bit 8080-style parallel LCD bus: paces write/read strobes from a
// valid/ready command stream, sequences the panel hardware reset and registers the backlight.
module lcd_bus_master #(
    parameter int unsigned TWRL  = 2,
    parameter int unsigned TWRH  = 2,
    parameter int unsigned TRDL  = 4,
    parameter int unsigned TRDH  = 2,
    parameter int unsigned TRST  = 1000,
    parameter int unsigned TRSTW = 2000
) (
    input  logic        pclk,
    input  logic        prst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rd,
    input  logic        req_rs,
    input  logic [23:0] req_data,
    output logic        rsp_valid,
    output logic [23:0] rsp_data,
    input  logic        reset_req,
    input  logic        blk_en,
    output logic        busy,
    output logic        blk,
    output logic        cs,
    output logic        rs,
    output logic        wr,
    output logic        rd,
    output logic        rst,
    output logic [23:0] data_o,
    output logic        data_oe,
    input  logic [23:0] data_i
);

    typedef enum logic [2:0] {
        StRstLo, StRstWait, StIdle, StSetup, StWrLo, StWrHi, StRdLo, StRdHi
    } state_e;

    state_e      state_q;
    logic [15:0] cnt_q;
    logic        is_rd_q;
    logic        ready_q;
    logic        cs_q, rs_q, wr_q, rd_q, rst_q, oe_q, blk_q, busy_q;
    logic [23:0] data_q;
    logic        rsp_valid_q;
    logic [23:0] rsp_data_q;
    logic        start;

    // A pending panel reset request withdraws ready in IDLE so the command is not taken.
    assign req_ready = ready_q & ~(reset_req & (state_q == StIdle));
    assign start     = req_valid & req_ready;

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state_q     <= StRstLo;
            cnt_q       <= 16'(TRST - 1);
            is_rd_q     <= 1'b0;
            ready_q     <= 1'b0;
            cs_q        <= 1'b1;
            rs_q        <= 1'b0;
            wr_q        <= 1'b1;
            rd_q        <= 1'b1;
            rst_q       <= 1'b0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b1;
            data_q      <= 24'h0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 24'h0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (start) begin
                state_q <= StSetup;
                is_rd_q <= req_rd;
                ready_q <= 1'b0;
                busy_q  <= 1'b1;
                cs_q    <= 1'b0;
                rs_q    <= req_rs;
                data_q  <= req_rd ? 24'h0 : req_data;
                oe_q    <= ~req_rd;
            end else begin
                unique case (state_q)
                    StRstLo: begin
                        if (cnt_q == 16'd0) begin
                            state_q <= StRstWait;
                            rst_q   <= 1'b1;
                            cnt_q   <= 16'(TRSTW - 1);
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    StRstWait: begin
                        if (cnt_q == 16'd0) begin
                            state_q <= StIdle;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    StIdle: begin
                        if (reset_req) begin
                            state_q <= StRstLo;
                            rst_q   <= 1'b0;
                            cnt_q   <= 16'(TRST - 1);
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end
                    StSetup: begin
                        if (is_rd_q) begin
                            state_q <= StRdLo;
                            rd_q    <= 1'b0;
                            cnt_q   <= 16'(TRDL - 1);
                        end else begin
                            state_q <= StWrLo;
                            wr_q    <= 1'b0;
                            cnt_q   <= 16'(TWRL - 1);
                        end
                    end
                    StWrLo: begin
                        if (cnt_q == 16'd0) begin
                            state_q <= StWrHi;
                            wr_q    <= 1'b1;
                            cnt_q   <= 16'(TWRH - 1);
                            ready_q <= (TWRH == 1);
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    StRdLo: begin
                        if (cnt_q == 16'd0) begin
                            state_q     <= StRdHi;
                            rd_q        <= 1'b1;
                            cnt_q       <= 16'(TRDH - 1);
                            ready_q     <= (TRDH == 1);
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= data_i;
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    StWrHi, StRdHi: begin
                        if (cnt_q == 16'd0) begin
                            state_q <= StIdle;
                            cs_q    <= 1'b1;
                            oe_q    <= 1'b0;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                            // Raise ready one edge early so it is registered in the last hold cycle.
                            if (cnt_q == 16'd1) begin
                                ready_q <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            blk_q <= 1'b0;
        end else begin
            blk_q <= blk_en;
        end
    end

    assign busy      = busy_q;
    assign blk       = blk_q;
    assign cs        = cs_q;
    assign rs        = rs_q;
    assign wr        = wr_q;
    assign rd        = rd_q;
    assign rst       = rst_q;
    assign data_o    = data_q;
    assign data_oe   = oe_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_lcd_bus_master.sv
// Self-checking bench for lcd_bus_master: reset sequencing, table-driven transfers with a
// scoreboard, back-to-back writes, reset priority, asynchronous abort and backlight.
module tb_lcd_bus_master;

    localparam int unsigned TWRL  = 2;
    localparam int unsigned TWRH  = 2;
    localparam int unsigned TRDL  = 4;
    localparam int unsigned TRDH  = 2;
    localparam int unsigned TRST  = 4;
    localparam int unsigned TRSTW = 8;

    logic        pclk = 1'b0;
    logic        prst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rd = 1'b0;
    logic        req_rs = 1'b0;
    logic [23:0] req_data = 24'h0;
    logic        rsp_valid;
    logic [23:0] rsp_data;
    logic        reset_req = 1'b0;
    logic        blk_en = 1'b1;
    logic        busy, blk, cs, rs, wr, rd, rst;
    logic [23:0] data_o;
    logic        data_oe;
    logic [23:0] data_i = 24'h0;

    lcd_bus_master #(
        .TWRL (TWRL),
        .TWRH (TWRH),
        .TRDL (TRDL),
        .TRDH (TRDH),
        .TRST (TRST),
        .TRSTW(TRSTW)
    ) dut (
        .pclk     (pclk),
        .prst     (prst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_rd   (req_rd),
        .req_rs   (req_rs),
        .req_data (req_data),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .reset_req(reset_req),
        .blk_en   (blk_en),
        .busy     (busy),
        .blk      (blk),
        .cs       (cs),
        .rs       (rs),
        .wr       (wr),
        .rd       (rd),
        .rst      (rst),
        .data_o   (data_o),
        .data_oe  (data_oe),
        .data_i   (data_i)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        rd;
        logic        rs;
        logic [23:0] wdata;
        logic [23:0] bus_rdata;
        logic [23:0] exp_data;
    } vec_t;

    typedef struct {
        logic        rd;
        logic        rs;
        logic [23:0] data;
    } sb_t;

    int  checks = 0;
    int  errors = 0;
    sb_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Waits (bounded) for req_ready at a negedge sample; returns number of samples taken.
    task automatic wait_ready(input int limit, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        while (n < limit) begin
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge pclk);
            n++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          l, h, p, n;
        bit          ok;
        logic [6:0]  exp_ctrl;
        sb_t         e;
        l = v.rd ? TRDL : TWRL;
        h = v.rd ? TRDH : TWRH;
        p = 1 + l + h;
        req_rd    = v.rd;
        req_rs    = v.rs;
        req_data  = v.wdata;
        req_valid = 1'b1;
        wait_ready(50, n, ok);
        check("accept_timeout", {31'd0, ok}, 32'd1);
        if (!ok) begin
            req_valid = 1'b0;
            return;
        end
        sb.push_back('{rd: v.rd, rs: v.rs, data: v.exp_data});
        @(posedge pclk);
        for (int j = 1; j <= p; j++) begin
            @(negedge pclk);
            if (j == 1) req_valid = 1'b0;
            exp_ctrl = {1'b0,
                        ~(!v.rd && j >= 2 && j <= 1 + l),
                        ~(v.rd && j >= 2 && j <= 1 + l),
                        v.rs, ~v.rd, (j == p), (v.rd && j == 2 + l)};
            check("ctrl{cs,wr,rd,rs,oe,rdy,rv}", {25'd0, cs, wr, rd, rs, data_oe, req_ready,
                  rsp_valid}, {25'd0, exp_ctrl});
            if (!v.rd) check("data_o_hold", {8'd0, data_o}, {8'd0, v.exp_data});
            if ((!v.rd && j == 2 && wr === 1'b0) || rsp_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_kind", {31'd0, v.rd}, {31'd0, e.rd});
                    check("sb_rs", {31'd0, rs}, {31'd0, e.rs});
                    check(v.rd ? "sb_rsp_data" : "sb_data_o",
                          {8'd0, v.rd ? rsp_data : data_o}, {8'd0, e.data});
                end
            end
            data_i = (rd === 1'b0) ? v.bus_rdata : 24'h0;
        end
        @(negedge pclk);
        check("idle{cs,oe,rdy,busy}", {28'd0, cs, data_oe, req_ready, busy}, 32'b1010);
    endtask

    vec_t vecs[6];

    initial begin
        int         n;
        bit         ok;
        bit         cs_low;
        int         acc2;
        logic       prev_blk;
        logic [7:0] pat;

        vecs[0] = '{rd: 1'b0, rs: 1'b1, wdata: 24'hA5C3F0, bus_rdata: 24'h0,
                    exp_data: 24'hA5C3F0};
        vecs[1] = '{rd: 1'b1, rs: 1'b1, wdata: 24'h0, bus_rdata: 24'h0F0F0F,
                    exp_data: 24'h0F0F0F};
        vecs[2] = '{rd: 1'b0, rs: 1'b0, wdata: 24'h00002C, bus_rdata: 24'h0,
                    exp_data: 24'h00002C};
        vecs[3] = '{rd: 1'b1, rs: 1'b0, wdata: 24'h0, bus_rdata: 24'hF00FF0,
                    exp_data: 24'hF00FF0};
        vecs[4] = '{rd: 1'b0, rs: 1'b1, wdata: 24'hFFFFFF, bus_rdata: 24'h0,
                    exp_data: 24'hFFFFFF};
        vecs[5] = '{rd: 1'b1, rs: 1'b1, wdata: 24'h0, bus_rdata: 24'hFFFFFF,
                    exp_data: 24'hFFFFFF};

        // Reset state while prst is held.
        repeat (2) @(negedge pclk);
        check("rst_state{blk,cs,rs,wr,rd,rst,oe,rdy,rv,busy}",
              {22'd0, blk, cs, rs, wr, rd, rst, data_oe, req_ready, rsp_valid, busy},
              32'b0101100001);
        check("rst_data", {8'd0, data_o, rsp_data[7:0]}, 32'd0);

        // Power-up sequence after release.
        prst = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            @(negedge pclk);
            check("pwr_rst", {31'd0, rst}, {31'd0, (i >= 4)});
            check("pwr_ready", {31'd0, req_ready}, {31'd0, (i >= 12)});
            check("pwr_strobes", {29'd0, cs, wr, rd}, 32'b111);
        end

        foreach (vecs[k]) run_vec(vecs[k]);

        // Back-to-back writes with req_valid held.
        req_rd = 1'b0; req_rs = 1'b0; req_data = 24'h00002C; req_valid = 1'b1;
        wait_ready(50, n, ok);
        check("b2b_accept1", {31'd0, ok}, 32'd1);
        @(posedge pclk);
        acc2 = 0;
        for (int j = 1; j <= 11; j++) begin
            @(negedge pclk);
            if (j == 1) begin req_rs = 1'b1; req_data = 24'h123456; end
            if (j == 6) req_valid = 1'b0;
            if (j <= 10) begin
                check("b2b_cs", {31'd0, cs}, 32'd0);
                check("b2b_rs", {31'd0, rs}, {31'd0, (j >= 6)});
                check("b2b_wr", {31'd0, wr}, {31'd0, !(j == 2 || j == 3 || j == 7 || j == 8)});
                check("b2b_data", {8'd0, data_o}, (j >= 6) ? 32'h123456 : 32'h00002C);
            end else begin
                check("b2b_idle_cs", {31'd0, cs}, 32'd1);
            end
            if (req_valid && req_ready && acc2 == 0) acc2 = j;
        end
        check("b2b_spacing", acc2, 32'd5);

        // reset_req beats req_valid in IDLE.
        @(negedge pclk);
        req_rd = 1'b0; req_rs = 1'b1; req_data = 24'h777777;
        reset_req = 1'b1; req_valid = 1'b1;
        #1;
        check("prio_no_ready", {31'd0, req_ready}, 32'd0);
        @(negedge pclk);
        check("prio_rst_lo{rst,busy,cs}", {29'd0, rst, busy, cs}, 32'b011);
        reset_req = 1'b0; req_valid = 1'b0;
        cs_low = 1'b0;
        n = 0;
        ok = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge pclk);
            if (cs !== 1'b1) cs_low = 1'b1;
            if (req_ready === 1'b1) begin n = k; ok = 1'b1; break; end
        end
        check("prio_recover_cycles", n, 32'd12);
        check("prio_no_transfer", {31'd0, cs_low}, 32'd0);

        // prst asserted mid-cycle during WR_LO.
        req_rd = 1'b0; req_rs = 1'b1; req_data = 24'h555555; req_valid = 1'b1;
        wait_ready(50, n, ok);
        @(posedge pclk);
        @(negedge pclk);
        req_valid = 1'b0;
        @(negedge pclk);
        check("abort_in_wr_lo", {31'd0, wr}, 32'd0);
        #2 prst = 1'b1;
        #1;
        check("abort{wr,cs,rst,rd,oe,blk,busy}", {25'd0, wr, cs, rst, rd, data_oe, blk, busy},
              32'b1101001);
        @(negedge pclk);
        prst = 1'b0;
        wait_ready(30, n, ok);
        check("abort_recover_cycles", n, 32'd12);

        // Backlight follows blk_en one cycle later during a transfer.
        req_rd = 1'b1; req_rs = 1'b0; req_valid = 1'b1;
        wait_ready(50, n, ok);
        @(posedge pclk);
        pat = 8'b1011_0010;
        prev_blk = blk_en;
        for (int i = 0; i < 8; i++) begin
            @(negedge pclk);
            if (i == 0) req_valid = 1'b0;
            check("blk_follow", {31'd0, blk}, {31'd0, prev_blk});
            blk_en = pat[i];
            prev_blk = pat[i];
        end
        @(negedge pclk);
        check("blk_last", {31'd0, blk}, {31'd0, prev_blk});
        wait_ready(50, n, ok);
        check("sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
